// File: rtl/mac_seg_tx_mon.sv
// MAC-side sink and statistics monitor for the F-Tile segmented TX interface.
// Optional length checking (runt/oversize counters) is enabled by defining MAC_SEG_TX_MON_LEN_CHECK_EN.
module mac_seg_tx_mon #(
    parameter int SEGMENTS      = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int MAX_FRAME_LEN = 16383
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [SEGMENTS*64-1:0]   SEG_DATA,
    input  logic [SEGMENTS-1:0]      SEG_INFRAME,
    input  logic [SEGMENTS*3-1:0]    SEG_EOP_EMPTY,
    input  logic [SEGMENTS-1:0]      SEG_ERROR,
    input  logic                     SEG_VALID,
    output logic                     SEG_READY,
    input  logic                     PAUSE,
    input  logic                     CNT_CLR,
    output logic                     FRAME_DONE,
    output logic [15:0]              FRAME_LEN,
    output logic                     FRAME_ERR,
    output logic [CNT_WIDTH-1:0]     FRAME_CNT,
    output logic [CNT_WIDTH-1:0]     BYTE_CNT,
    output logic [CNT_WIDTH-1:0]     ERR_CNT,
    output logic [CNT_WIDTH-1:0]     RUNT_CNT,
    output logic [CNT_WIDTH-1:0]     OVERSIZE_CNT
);

    localparam logic [31:0] MAX_LEN_C = 32'(MAX_FRAME_LEN);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [15:0]          b);
        logic [CNT_WIDTH+16:0] s;
        s = {17'd0, a} + {{(CNT_WIDTH+1){1'b0}}, b};
        if (|s[CNT_WIDTH+16:CNT_WIDTH]) begin
            return '1;
        end else begin
            return s[CNT_WIDTH-1:0];
        end
    endfunction

    logic                 ready_q;
    logic                 last_inframe_q;
    logic [15:0]          acc_q, acc_d;
    logic                 done_q, done_d;
    logic [15:0]          len_q, len_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                 accept_s;
    logic                 prev_s;
    logic [16:0]          sum_s;
    logic                 eop_s;
    logic [15:0]          eop_len_s;
    logic                 eop_err_s;
    logic                 count_s;
    logic                 unused_s;

    assign accept_s = SEG_VALID & ready_q;
    assign count_s  = accept_s & eop_s & ~CNT_CLR;
    assign unused_s = ^{SEG_DATA, MAX_LEN_C};

    // Walk the segments in order, tracking SOP/body/EOP and the saturating length accumulator.
    always_comb begin
        acc_d     = acc_q;
        prev_s    = last_inframe_q;
        sum_s     = 17'd0;
        eop_s     = 1'b0;
        eop_len_s = 16'd0;
        eop_err_s = 1'b0;
        for (int i = 0; i < SEGMENTS; i++) begin
            if (SEG_INFRAME[i] && !prev_s) begin
                acc_d = 16'd8;
            end else if (SEG_INFRAME[i]) begin
                sum_s = {1'b0, acc_d} + 17'd8;
                acc_d = sum_s[16] ? 16'hFFFF : sum_s[15:0];
            end else if (prev_s) begin
                // The EOP segment carries data too; only its empty bytes are dropped.
                sum_s     = {1'b0, acc_d} + 17'd8 - {14'd0, SEG_EOP_EMPTY[3*i +: 3]};
                eop_len_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];
                eop_s     = 1'b1;
                eop_err_s = SEG_ERROR[i];
                acc_d     = 16'd0;
            end else begin
                acc_d = acc_d;
            end
            prev_s = SEG_INFRAME[i];
        end
    end

    // Frame report and common statistics next-state; a clear overrides a same-cycle EOP.
    always_comb begin
        done_d      = accept_s & eop_s;
        len_d       = len_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept_s && eop_s) begin
            len_d = eop_len_s;
            err_d = eop_err_s;
        end else begin
            len_d = len_q;
            err_d = err_q;
        end
        if (CNT_CLR) begin
            frame_cnt_d = '0;
            byte_cnt_d  = '0;
            err_cnt_d   = '0;
        end else if (count_s) begin
            frame_cnt_d = sat_add(frame_cnt_q, 16'd1);
            byte_cnt_d  = sat_add(byte_cnt_q, eop_len_s);
            err_cnt_d   = eop_err_s ? sat_add(err_cnt_q, 16'd1) : err_cnt_q;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State, report and counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ready_q        <= 1'b0;
            last_inframe_q <= 1'b0;
            acc_q          <= 16'd0;
            done_q         <= 1'b0;
            len_q          <= 16'd0;
            err_q          <= 1'b0;
            frame_cnt_q    <= '0;
            byte_cnt_q     <= '0;
            err_cnt_q      <= '0;
        end else begin
            ready_q     <= ~PAUSE;
            done_q      <= done_d;
            len_q       <= len_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_cnt_q   <= err_cnt_d;
            if (accept_s) begin
                last_inframe_q <= SEG_INFRAME[SEGMENTS-1];
                acc_q          <= acc_d;
            end
        end
    end

`ifdef MAC_SEG_TX_MON_LEN_CHECK_EN
    logic [CNT_WIDTH-1:0] runt_cnt_q, runt_cnt_d;
    logic [CNT_WIDTH-1:0] ovs_cnt_q, ovs_cnt_d;

    // Runt and oversize counter next-state.
    always_comb begin
        runt_cnt_d = runt_cnt_q;
        ovs_cnt_d  = ovs_cnt_q;
        if (CNT_CLR) begin
            runt_cnt_d = '0;
            ovs_cnt_d  = '0;
        end else if (count_s) begin
            runt_cnt_d = (eop_len_s < 16'd64) ? sat_add(runt_cnt_q, 16'd1) : runt_cnt_q;
            ovs_cnt_d  = ({16'd0, eop_len_s} > MAX_LEN_C) ? sat_add(ovs_cnt_q, 16'd1) : ovs_cnt_q;
        end else begin
            runt_cnt_d = runt_cnt_q;
        end
    end

    // Runt and oversize counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            runt_cnt_q <= '0;
            ovs_cnt_q  <= '0;
        end else begin
            runt_cnt_q <= runt_cnt_d;
            ovs_cnt_q  <= ovs_cnt_d;
        end
    end

    assign RUNT_CNT     = runt_cnt_q;
    assign OVERSIZE_CNT = ovs_cnt_q;
`else
    assign RUNT_CNT     = '0;
    assign OVERSIZE_CNT = '0;
`endif

    assign SEG_READY  = ready_q;
    assign FRAME_DONE = done_q;
    assign FRAME_LEN  = len_q;
    assign FRAME_ERR  = err_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign BYTE_CNT   = byte_cnt_q;
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_mac_seg_tx_mon.sv
// Directed self-checking bench for mac_seg_tx_mon (SEGMENTS=4); a second
// instance with 4-bit counters exercises saturation.
module tb_mac_seg_tx_mon;

`ifdef MAC_SEG_TX_MON_LEN_CHECK_EN
    localparam logic [63:0] LC = 64'd1;
`else
    localparam logic [63:0] LC = 64'd0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] seg_data;
    logic [3:0]   seg_inframe;
    logic [11:0]  seg_empty;
    logic [3:0]   seg_error;
    logic         seg_valid;
    logic         pause;
    logic         cnt_clr;

    logic         ready, done, ferr;
    logic [15:0]  flen;
    logic [31:0]  fcnt, bcnt, ecnt, rcnt, ocnt;
    logic         s_ready, s_done, s_ferr;
    logic [15:0]  s_flen;
    logic [3:0]   s_fcnt, s_bcnt, s_ecnt, s_rcnt, s_ocnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_seg_tx_mon #(.SEGMENTS(4), .CNT_WIDTH(32), .MAX_FRAME_LEN(16383)) u_dut (
        .CLK(clk), .RESET(rst), .SEG_DATA(seg_data), .SEG_INFRAME(seg_inframe),
        .SEG_EOP_EMPTY(seg_empty), .SEG_ERROR(seg_error), .SEG_VALID(seg_valid),
        .SEG_READY(ready), .PAUSE(pause), .CNT_CLR(cnt_clr), .FRAME_DONE(done),
        .FRAME_LEN(flen), .FRAME_ERR(ferr), .FRAME_CNT(fcnt), .BYTE_CNT(bcnt),
        .ERR_CNT(ecnt), .RUNT_CNT(rcnt), .OVERSIZE_CNT(ocnt)
    );

    mac_seg_tx_mon #(.SEGMENTS(4), .CNT_WIDTH(4), .MAX_FRAME_LEN(16383)) u_dut_sat (
        .CLK(clk), .RESET(rst), .SEG_DATA(seg_data), .SEG_INFRAME(seg_inframe),
        .SEG_EOP_EMPTY(seg_empty), .SEG_ERROR(seg_error), .SEG_VALID(seg_valid),
        .SEG_READY(s_ready), .PAUSE(pause), .CNT_CLR(cnt_clr), .FRAME_DONE(s_done),
        .FRAME_LEN(s_flen), .FRAME_ERR(s_ferr), .FRAME_CNT(s_fcnt), .BYTE_CNT(s_bcnt),
        .ERR_CNT(s_ecnt), .RUNT_CNT(s_rcnt), .OVERSIZE_CNT(s_ocnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [3:0] inf, input logic [11:0] emp,
                       input logic [3:0] err);
        @(negedge clk);
        seg_valid   = v;
        seg_inframe = inf;
        seg_empty   = emp;
        seg_error   = err;
        seg_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; cnt_clr = 1'b0; seg_valid = 1'b0;
        seg_inframe = 4'd0; seg_empty = 12'd0; seg_error = 4'd0; seg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_len", flen, 64'd0);
        chk("rst_fcnt", fcnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_rise", ready, 64'd1);

        // 64 B frame
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        chk("f64_no_done", done, 64'd0);
        cyc(1'b1, 4'b0111, 12'd0, 4'd0);
        chk("f64_done", done, 64'd1);
        chk("f64_len", flen, 64'd64);
        chk("f64_fcnt", fcnt, 64'd1);
        chk("f64_bcnt", bcnt, 64'd64);
        cyc(1'b0, 4'b0000, 12'd0, 4'd0);
        chk("f64_pulse", done, 64'd0);
        chk("f64_hold", flen, 64'd64);

        // Back-to-back: EOP at seg0 then SOP at seg2
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b1100, 12'h005, 4'd0);
        chk("b2b_done", done, 64'd1);
        chk("b2b_len67", flen, 64'd67);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'h002, 4'd0);
        chk("b2b_len86", flen, 64'd86);
        chk("b2b_fcnt", fcnt, 64'd3);
        chk("b2b_bcnt", bcnt, 64'd217);

        // Backpressure
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        pause = 1'b1;
        cyc(1'b0, 4'b0000, 12'd0, 4'd0);
        chk("bp_ready0", ready, 64'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0000, 12'd0, 4'd0);
        chk("bp_no_done", done, 64'd0);
        chk("bp_fcnt", fcnt, 64'd3);
        pause = 1'b0;
        cyc(1'b0, 4'b0000, 12'd0, 4'd0);
        chk("bp_ready1", ready, 64'd1);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'd0, 4'd0);
        chk("bp_len72", flen, 64'd72);
        chk("bp_fcnt4", fcnt, 64'd4);
        chk("bp_bcnt", bcnt, 64'd289);

        // Error + runt, then error bits on non-EOP segments
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'd0, 4'b0001);
        chk("runt_len", flen, 64'd40);
        chk("runt_ferr", ferr, 64'd1);
        chk("runt_ecnt", ecnt, 64'd1);
        chk("runt_rcnt", rcnt, LC);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0111, 12'd0, 4'b0111);
        chk("noerr_ferr", ferr, 64'd0);
        chk("noerr_ecnt", ecnt, 64'd1);
        chk("noerr_fcnt", fcnt, 64'd6);

        // Oversize frame, then a saturated-length frame
        for (int k = 0; k < 520; k++) cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'd0, 4'd0);
        chk("ovs_len", flen, 64'd16648);
        chk("ovs_ocnt", ocnt, LC);
        chk("ovs_rcnt", rcnt, LC);
        for (int k = 0; k < 2100; k++) cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'h007, 4'd0);
        chk("sat_len", flen, 64'hFFFF);
        chk("sat_ocnt", ocnt, 2 * LC);
        chk("sat_bcnt", bcnt, 64'd82576);
        chk("s_fcnt8", s_fcnt, 64'd8);
        chk("s_bcnt_sat", s_bcnt, 64'd15);

        // Eight more frames: 4-bit FRAME_CNT saturates at 15
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 4'b1111, 12'd0, 4'd0);
            cyc(1'b1, 4'b0111, 12'd0, 4'd0);
        end
        chk("s_fcnt15", s_fcnt, 64'd15);
        chk("s_ecnt", s_ecnt, 64'd1);
        chk("m_fcnt16", fcnt, 64'd16);
        chk("m_bcnt", bcnt, 64'd83088);

        // Clear together with an EOP
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cnt_clr = 1'b1;
        cyc(1'b1, 4'b0111, 12'd0, 4'b1000);
        cnt_clr = 1'b0;
        chk("clr_done", done, 64'd1);
        chk("clr_len", flen, 64'd64);
        chk("clr_fcnt", fcnt, 64'd0);
        chk("clr_bcnt", bcnt, 64'd0);
        chk("clr_ecnt", ecnt, 64'd0);
        chk("clr_rcnt", rcnt, 64'd0);
        chk("clr_ocnt", ocnt, 64'd0);
        chk("clr_s_fcnt", s_fcnt, 64'd0);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0111, 12'd0, 4'd0);
        chk("postclr_fcnt", fcnt, 64'd1);
        chk("postclr_bcnt", bcnt, 64'd64);

        // Reset mid-frame
        cyc(1'b1, 4'b1110, 12'd0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        seg_valid = 1'b1;
        seg_inframe = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("midrst_ready", ready, 64'd0);
        end
        chk("midrst_fcnt", fcnt, 64'd0);
        chk("midrst_len", flen, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seg_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready1", ready, 64'd1);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b1111, 12'd0, 4'd0);
        cyc(1'b1, 4'b0000, 12'd0, 4'd0);
        chk("midrst_len72", flen, 64'd72);
        chk("midrst_fcnt1", fcnt, 64'd1);
        chk("midrst_bcnt", bcnt, 64'd72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
